// File: rtl/result_display_pkg.sv
// Shared types and the seven-segment decode table for the board result harnesses.
package result_display_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // {g,f,e,d,c,b,a}, active-low; non-decimal nibbles show blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/result_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, N steps per conversion.
module bin2bcd_seq
  import result_display_pkg::*;
#(
  parameter int N          = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N-1:0]            bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = 4 * BCD_DIGITS;

  logic [N-1:0]    shift_q, shift_d;
  logic [BW-1:0]   bcd_q, bcd_d, adj;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic [BW+N-1:0] cat;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    cat = {adj, shift_q} << 1;
    bcd_d   = cat[BW+N-1:N];
    shift_d = cat[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      shift_q <= bin;
      bcd_q   <= '0;
      cnt_q   <= CW'(N);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  // High during the final step so the owner can leave CONVERT on that same edge
  assign done = busy_q && (cnt_q == CW'(1));
  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/result_display.sv
// Result sink: accepts a value, converts to BCD, shows it on LEDs and a scanned 7-seg display.
module result_display
  import result_display_pkg::*;
#(
  parameter int N           = 16,
  parameter int DIGITS      = 4,
  parameter int BCD_DIGITS  = 5,
  parameter int REFRESH_DIV = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in0,
  output logic [N-1:0]      leds,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = 4 * BCD_DIGITS;

  state_e                 state_q, state_d;
  logic [N-1:0]           leds_q;
  logic [BW-1:0]          shown_q, conv_bcd;
  logic                   ovf_q;
  logic [REFRESH_DIV-1:0] scan_q;
  logic [DW-1:0]          dig_q;
  logic                   accept, conv_busy, conv_done;
  logic [4*DIGITS-1:0]    low, higher;
  logic                   blank;

  assign in_ready = (state_q == S_IDLE) && !conv_busy;
  assign accept   = in_valid && in_ready;

  bin2bcd_seq #(.N(N), .BCD_DIGITS(BCD_DIGITS)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (in0),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept)    state_d = S_CONVERT;
      S_CONVERT: if (conv_done) state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      leds_q  <= '0;
      shown_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) leds_q <= in0;
      if (state_q == S_DONE) begin
        shown_q <= conv_bcd;
        ovf_q   <= |conv_bcd[BW-1:4*DIGITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      dig_q  <= '0;
    end else begin
      scan_q <= scan_q + 1'b1;
      if (&scan_q) dig_q <= (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
    end
  end

  // Blank when this digit and everything above it is zero; overflow shows all digits
  always_comb begin
    low    = shown_q[4*DIGITS-1:0];
    higher = low >> {dig_q, 2'b00};
    blank  = !ovf_q && (dig_q != '0) && (higher == '0);
    seg    = blank ? SEG_BLANK : seg7(higher[3:0]);
  end

  assign an   = ~(DIGITS'(1) << dig_q);
  assign dp   = ~ovf_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench: stimulus pushes expected displays, a monitor scans all digits on each output event.
module tb_result_display;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in0 = '0;
  logic [N-1:0]  leds;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;

  result_display #(.N(N), .DIGITS(4), .BCD_DIGITS(5), .REFRESH_DIV(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in0(in0),
    .leds(leds), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111;

  typedef struct {
    logic [N-1:0]    leds;
    logic [3:0][6:0] seg;   // index = digit position, 0 = least significant
    logic            dp;
    bit              chk_low;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [N-1:0] l, input logic [6:0] d0, input logic [6:0] d1,
                              input logic [6:0] d2, input logic [6:0] d3, input logic p, input bit cl);
    exp_t e;
    e.leds = l;
    e.seg[0] = d0; e.seg[1] = d1; e.seg[2] = d2; e.seg[3] = d3;
    e.dp = p;
    e.chk_low = cl;
    return e;
  endfunction

  // Monitor: an output event is in_ready rising outside reset, or reset releasing
  bit              collecting = 0;
  logic            prev_rdy = 1'bx, prev_rst = 1'bx;
  int              lowcnt = 0, lowlast = 0, cyc = 0;
  logic [3:0]      seen;
  logic [3:0][6:0] got;
  bit              dp_bad, an_bad;
  exp_t            cur;

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit trig;
        int idx;
        trig = (rst === 1'b0 && prev_rdy === 1'b0 && in_ready === 1'b1) ||
               (prev_rst === 1'b1 && rst === 1'b0);
        if (in_ready === 1'b0) lowcnt++;
        else begin
          if (prev_rdy === 1'b0) lowlast = lowcnt;
          lowcnt = 0;
        end
        prev_rdy = in_ready;
        prev_rst = rst;
        if (trig) begin
          if (collecting) begin
            failures++; checks++;
            $display("FAIL overlap event while scanning previous result");
          end
          if (exp_q.size() == 0) begin
            failures++; checks++;
            $display("FAIL unexpected_event leds=%0d", leds);
            collecting = 0;
          end else begin
            cur = exp_q.pop_front();
            chk("leds", 32'(leds), 32'(cur.leds));
            if (cur.chk_low) chk("ready_low_cycles", lowlast, 17);
            collecting = 1;
            seen = '0; dp_bad = 0; an_bad = 0; cyc = 0;
          end
        end
        if (collecting) begin
          case (an)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
          endcase
          if (idx < 0) an_bad = 1;
          else begin
            got[idx] = seg;
            seen[idx] = 1'b1;
          end
          if (dp !== cur.dp) dp_bad = 1;
          cyc++;
          if (&seen) begin
            chk("seg_digit0", 32'(got[0]), 32'(cur.seg[0]));
            chk("seg_digit1", 32'(got[1]), 32'(cur.seg[1]));
            chk("seg_digit2", 32'(got[2]), 32'(cur.seg[2]));
            chk("seg_digit3", 32'(got[3]), 32'(cur.seg[3]));
            chk("dp_all_digits", 32'(dp_bad), 32'(0));
            chk("an_one_hot_low", 32'(an_bad), 32'(0));
            collecting = 0;
          end else if (cyc > 40) begin
            failures++; checks++;
            $display("FAIL scan_timeout seen=%b expected=1111", seen);
            collecting = 0;
          end
        end
      end
    end
  end

  task automatic hold_until_accept();
    int k = 0;
    while (in_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      failures++; checks++;
      $display("FAIL accept_timeout in_ready=%b expected=1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in0 = v;
    hold_until_accept();
    in_valid = 1'b0;
  endtask

  task automatic gap();
    repeat (40) @(negedge clk);
  endtask

  initial begin
    exp_q.push_back(mk(16'd0, S0, SB, SB, SB, 1'b1, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    gap();

    exp_q.push_back(mk(16'd89, S9, S8, SB, SB, 1'b1, 1));
    send(16'd89);
    gap();

    exp_q.push_back(mk(16'd46368, S8, S6, S3, S6, 1'b0, 1));
    send(16'd46368);
    gap();

    // Back-to-back with valid held: 144 waits for ready, nothing lost
    exp_q.push_back(mk(16'd89, S9, S8, SB, SB, 1'b1, 1));
    exp_q.push_back(mk(16'd144, S4, S4, S1, SB, 1'b1, 1));
    @(negedge clk);
    in_valid = 1'b1;
    in0 = 16'd89;
    hold_until_accept();
    in0 = 16'd144;
    hold_until_accept();
    in_valid = 1'b0;
    gap();

    exp_q.push_back(mk(16'd6765, S5, S6, S7, S6, 1'b1, 1));
    send(16'd6765);
    gap();

    exp_q.push_back(mk(16'd0, S0, SB, SB, SB, 1'b1, 1));
    send(16'd0);
    gap();

    // Reset mid-conversion: no result for 1000, display returns to reset state
    exp_q.push_back(mk(16'd0, S0, SB, SB, SB, 1'b1, 0));
    send(16'd1000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gap();

    exp_q.push_back(mk(16'd1000, S0, S0, S0, S1, 1'b1, 1));
    send(16'd1000);
    gap();

    begin
      int k = 0;
      while ((exp_q.size() != 0 || collecting) && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    chk("pending_expected", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
